// File: rtl/snake_score_keeper.sv
// Running game score for the snake scoreboard: digit-serial BCD adder with
// food-event buffering, 9999 saturation, game-over/new-game sequencing and high score.
module snake_score_keeper #(
  parameter int SCORE_WIDTH = 16,
  parameter int POINTS      = 1,
  parameter int PEND_WIDTH  = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_FoodEaten,
  input  logic                   i_GameOver,
  input  logic                   i_NewGame,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic [SCORE_WIDTH-1:0] o_HighScore,
  output logic                   o_Busy,
  output logic                   o_NewHigh,
  output logic                   o_Saturated
);

  typedef enum logic [1:0] {IDLE, ADD, OVER} state_t;

  localparam logic [3:0]            POINTS_BCD  = 4'(POINTS);
  localparam logic [PEND_WIDTH-1:0] PENDING_MAX = {PEND_WIDTH{1'b1}};
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = SCORE_WIDTH'(16'h9999);

  state_t                  state;
  logic [1:0]              digit_idx;
  logic                    carry;
  logic                    over_req;
  logic [PEND_WIDTH-1:0]   pending;
  logic [SCORE_WIDTH-1:0]  work;

  logic [3:0]              digit_in;
  logic [3:0]              addend;
  logic [4:0]              sum;
  logic [3:0]              digit_out;
  logic                    carry_out;
  logic [SCORE_WIDTH-1:0]  work_next;
  logic [SCORE_WIDTH-1:0]  commit_val;
  logic                    go_over;

  // One BCD digit of the working copy is updated per clock; o_Score only sees the final result.
  always_comb begin
    digit_in  = work[{digit_idx, 2'b00} +: 4];
    addend    = (digit_idx == 2'd0) ? POINTS_BCD : 4'd0;
    sum       = {1'b0, digit_in} + {1'b0, addend} + {4'd0, carry};
    digit_out = sum[3:0];
    carry_out = 1'b0;
    if (sum > 5'd9) begin
      digit_out = 4'(sum - 5'd10);
      carry_out = 1'b1;
    end
    work_next = work;
    work_next[{digit_idx, 2'b00} +: 4] = digit_out;
    commit_val = carry_out ? SCORE_MAX : work_next;
    go_over    = over_req | i_GameOver;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      digit_idx   <= 2'd0;
      carry       <= 1'b0;
      over_req    <= 1'b0;
      pending     <= '0;
      work        <= '0;
      o_Score     <= '0;
      o_HighScore <= '0;
      o_Busy      <= 1'b0;
      o_NewHigh   <= 1'b0;
      o_Saturated <= 1'b0;
    end else if (i_NewGame) begin
      state       <= IDLE;
      digit_idx   <= 2'd0;
      carry       <= 1'b0;
      over_req    <= 1'b0;
      pending     <= '0;
      o_Score     <= '0;
      o_Busy      <= 1'b0;
      o_NewHigh   <= 1'b0;
      o_Saturated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_GameOver) begin
            pending <= '0;
            state   <= OVER;
            if (o_Score > o_HighScore) begin
              o_HighScore <= o_Score;
              o_NewHigh   <= 1'b1;
            end
          end else if (o_Saturated) begin
            pending <= '0;
          end else if (i_FoodEaten || pending != '0) begin
            work      <= o_Score;
            digit_idx <= 2'd0;
            carry     <= 1'b0;
            state     <= ADD;
            o_Busy    <= 1'b1;
            if (!i_FoodEaten) pending <= pending - 1'b1;
          end
        end

        ADD: begin
          work      <= work_next;
          carry     <= carry_out;
          digit_idx <= digit_idx + 2'd1;
          if (i_GameOver) over_req <= 1'b1;
          else if (i_FoodEaten && pending != PENDING_MAX) pending <= pending + 1'b1;
          // Last digit: commit atomically, then decide between IDLE and OVER.
          if (digit_idx == 2'd3) begin
            o_Score  <= commit_val;
            o_Busy   <= 1'b0;
            over_req <= 1'b0;
            carry    <= 1'b0;
            if (carry_out) begin
              o_Saturated <= 1'b1;
              pending     <= '0;
            end
            if (go_over) begin
              state   <= OVER;
              pending <= '0;
              if (commit_val > o_HighScore) begin
                o_HighScore <= commit_val;
                o_NewHigh   <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end
        end

        OVER: begin
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_score_keeper.sv
// Directed self-checking bench for snake_score_keeper: a default instance plus
// POINTS=5 and PEND_WIDTH=2 instances for saturation and pending-limit cases.
module tb_snake_score_keeper;

  logic        clk;
  logic        rst;
  logic        food, go, ng;
  logic [15:0] score, high;
  logic        busy, new_high, sat;
  logic        food5, go5, ng5;
  logic [15:0] score5, high5;
  logic        busy5, new_high5, sat5;
  logic        food2, go2, ng2;
  logic [15:0] score2, high2;
  logic        busy2, new_high2, sat2;

  int passed = 0;
  int total  = 0;

  snake_score_keeper dut (
    .i_Clk(clk), .i_Reset(rst), .i_FoodEaten(food), .i_GameOver(go), .i_NewGame(ng),
    .o_Score(score), .o_HighScore(high), .o_Busy(busy), .o_NewHigh(new_high), .o_Saturated(sat)
  );

  snake_score_keeper #(.POINTS(5)) dut5 (
    .i_Clk(clk), .i_Reset(rst), .i_FoodEaten(food5), .i_GameOver(go5), .i_NewGame(ng5),
    .o_Score(score5), .o_HighScore(high5), .o_Busy(busy5), .o_NewHigh(new_high5), .o_Saturated(sat5)
  );

  snake_score_keeper #(.PEND_WIDTH(2)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_FoodEaten(food2), .i_GameOver(go2), .i_NewGame(ng2),
    .o_Score(score2), .o_HighScore(high2), .o_Busy(busy2), .o_NewHigh(new_high2), .o_Saturated(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bounded wait for the selected instance to leave ADD.
  task automatic wait_idle(input int which);
    int n = 0;
    logic b;
    b = (which == 0) ? busy : (which == 1) ? busy5 : busy2;
    while (b && n < 50) begin
      @(negedge clk);
      n++;
      b = (which == 0) ? busy : (which == 1) ? busy5 : busy2;
    end
    if (b) begin
      total++;
      $display("[TB] FAIL wait_idle[%0d]: busy still 1 after %0d cycles, required 0", which, n);
    end
  endtask

  task automatic add_main(input int count);
    for (int i = 0; i < count; i++) begin
      food = 1'b1; @(negedge clk); food = 1'b0;
      wait_idle(0);
    end
  endtask

  task automatic new_game_main;
    ng = 1'b1; @(negedge clk); ng = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (score !== 16'h0000) $display("[TB] FAIL reset_score: got %h required 0000", score); else passed++;
    total++; if (high !== 16'h0000) $display("[TB] FAIL reset_high: got %h required 0000", high); else passed++;
    total++; if ({busy, new_high, sat} !== 3'b000) $display("[TB] FAIL reset_flags: got %b required 000", {busy, new_high, sat}); else passed++;
    total++; if (score5 !== 16'h0000) $display("[TB] FAIL reset_score5: got %h required 0000", score5); else passed++;
  endtask

  task automatic test_single_food;
    food = 1'b1; @(negedge clk); food = 1'b0;
    total++; if ({busy, score} !== {1'b1, 16'h0000}) $display("[TB] FAIL single_edge0: got busy=%b score=%h required busy=1 score=0000", busy, score); else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++; if ({busy, score} !== {1'b1, 16'h0000}) $display("[TB] FAIL single_edge%0d: got busy=%b score=%h required busy=1 score=0000", i, busy, score); else passed++;
    end
    @(negedge clk);
    total++; if ({busy, score} !== {1'b0, 16'h0001}) $display("[TB] FAIL single_commit: got busy=%b score=%h required busy=0 score=0001", busy, score); else passed++;
  endtask

  task automatic test_carry_chain;
    logic bad = 1'b0;
    add_main(98);
    total++; if (score !== 16'h0099) $display("[TB] FAIL preload_99: got %h required 0099", score); else passed++;
    food = 1'b1; @(negedge clk); food = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (score !== 16'h0099 && score !== 16'h0100) bad = 1'b1;
      @(negedge clk);
    end
    total++; if (bad) $display("[TB] FAIL atomic_commit: intermediate score seen, last %h, required only 0099/0100", score); else passed++;
    total++; if (score !== 16'h0100) $display("[TB] FAIL carry_0100: got %h required 0100", score); else passed++;
  endtask

  task automatic test_back_to_back;
    new_game_main();
    total++; if (score !== 16'h0000) $display("[TB] FAIL b2b_cleared: got %h required 0000", score); else passed++;
    food = 1'b1; repeat (5) @(negedge clk); food = 1'b0;
    total++; if (score !== 16'h0001) $display("[TB] FAIL b2b_first: got %h required 0001", score); else passed++;
    repeat (19) @(negedge clk);
    total++; if ({busy, score} !== {1'b1, 16'h0004}) $display("[TB] FAIL b2b_fourth: got busy=%b score=%h required busy=1 score=0004", busy, score); else passed++;
    @(negedge clk);
    total++; if ({busy, score} !== {1'b0, 16'h0005}) $display("[TB] FAIL b2b_final: got busy=%b score=%h required busy=0 score=0005", busy, score); else passed++;
    repeat (10) @(negedge clk);
    total++; if ({busy, score} !== {1'b0, 16'h0005}) $display("[TB] FAIL b2b_drained: got busy=%b score=%h required busy=0 score=0005", busy, score); else passed++;
  endtask

  task automatic test_game_over;
    new_game_main();
    add_main(30);
    go = 1'b1; @(negedge clk); go = 1'b0;
    total++; if ({new_high, high} !== {1'b1, 16'h0030}) $display("[TB] FAIL over_first: got nh=%b high=%h required nh=1 high=0030", new_high, high); else passed++;
    new_game_main();
    total++; if ({new_high, score, high} !== {1'b0, 16'h0000, 16'h0030}) $display("[TB] FAIL newgame_1: got nh=%b score=%h high=%h required 0/0000/0030", new_high, score, high); else passed++;
    add_main(42);
    go = 1'b1; @(negedge clk); go = 1'b0;
    total++; if ({new_high, score, high} !== {1'b1, 16'h0042, 16'h0042}) $display("[TB] FAIL over_beaten: got nh=%b score=%h high=%h required 1/0042/0042", new_high, score, high); else passed++;
    food = 1'b1; @(negedge clk); food = 1'b0;
    repeat (5) @(negedge clk);
    total++; if ({busy, score} !== {1'b0, 16'h0042}) $display("[TB] FAIL over_food_ignored: got busy=%b score=%h required busy=0 score=0042", busy, score); else passed++;
    new_game_main();
    total++; if ({new_high, score, high} !== {1'b0, 16'h0000, 16'h0042}) $display("[TB] FAIL newgame_2: got nh=%b score=%h high=%h required 0/0000/0042", new_high, score, high); else passed++;
    add_main(5);
    food = 1'b1; @(negedge clk); @(negedge clk); food = 1'b0;
    go = 1'b1; @(negedge clk); go = 1'b0;
    wait_idle(0);
    repeat (6) @(negedge clk);
    total++; if ({busy, score, high, new_high} !== {1'b0, 16'h0006, 16'h0042, 1'b0}) $display("[TB] FAIL over_mid_add: got busy=%b score=%h high=%h nh=%b required 0/0006/0042/0", busy, score, high, new_high); else passed++;
  endtask

  task automatic test_new_game_mid_add;
    logic bad = 1'b0;
    new_game_main();
    add_main(7);
    total++; if (score !== 16'h0007) $display("[TB] FAIL abort_preload: got %h required 0007", score); else passed++;
    food = 1'b1; @(negedge clk); food = 1'b0;
    ng = 1'b1; @(negedge clk); ng = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (score !== 16'h0000 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    total++; if (bad || score !== 16'h0000) $display("[TB] FAIL abort_no_commit: got score=%h busy=%b required 0000/0", score, busy); else passed++;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 1999; i++) begin
      food5 = 1'b1; @(negedge clk); food5 = 1'b0;
      wait_idle(1);
    end
    total++; if ({sat5, score5} !== {1'b0, 16'h9995}) $display("[TB] FAIL sat_preload: got sat=%b score=%h required 0/9995", sat5, score5); else passed++;
    food5 = 1'b1; @(negedge clk); food5 = 1'b0;
    wait_idle(1);
    total++; if ({sat5, score5} !== {1'b1, 16'h9999}) $display("[TB] FAIL sat_clamp: got sat=%b score=%h required 1/9999", sat5, score5); else passed++;
    food5 = 1'b1; @(negedge clk); food5 = 1'b0;
    total++; if (busy5 !== 1'b0) $display("[TB] FAIL sat_no_start: got busy=%b required 0", busy5); else passed++;
    repeat (5) @(negedge clk);
    total++; if ({busy5, sat5, score5} !== {1'b0, 1'b1, 16'h9999}) $display("[TB] FAIL sat_hold: got busy=%b sat=%b score=%h required 0/1/9999", busy5, sat5, score5); else passed++;
    ng5 = 1'b1; @(negedge clk); ng5 = 1'b0;
    total++; if ({sat5, score5} !== {1'b0, 16'h0000}) $display("[TB] FAIL sat_newgame: got sat=%b score=%h required 0/0000", sat5, score5); else passed++;
  endtask

  task automatic test_pending_limit;
    food2 = 1'b1; repeat (5) @(negedge clk); food2 = 1'b0;
    repeat (30) @(negedge clk);
    total++; if ({busy2, score2} !== {1'b0, 16'h0004}) $display("[TB] FAIL pend_limit: got busy=%b score=%h required 0/0004", busy2, score2); else passed++;
  endtask

  task automatic test_reset_mid_add;
    new_game_main();
    add_main(3);
    food = 1'b1; @(negedge clk); food = 1'b0;
    total++; if ({busy, score} !== {1'b1, 16'h0003}) $display("[TB] FAIL rst_pre: got busy=%b score=%h required 1/0003", busy, score); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if ({score, high} !== 32'h0) $display("[TB] FAIL rst_async_scores: got score=%h high=%h required 0000/0000", score, high); else passed++;
    total++; if ({busy, new_high, sat} !== 3'b000) $display("[TB] FAIL rst_async_flags: got %b required 000", {busy, new_high, sat}); else passed++;
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if ({busy, score} !== {1'b0, 16'h0000}) $display("[TB] FAIL rst_no_commit: got busy=%b score=%h required 0/0000", busy, score); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    food = 1'b0; go = 1'b0; ng = 1'b0;
    food5 = 1'b0; go5 = 1'b0; ng5 = 1'b0;
    food2 = 1'b0; go2 = 1'b0; ng2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_food();
    test_carry_chain();
    test_back_to_back();
    test_game_over();
    test_new_game_mid_add();
    test_saturation();
    test_pending_limit();
    test_reset_mid_add();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
